// File: rtl/button_debouncer_if.sv
// Button conditioning bus: raw pins in, debounced level and edge pulses out.
// There is no valid/ready handshake on this bus: raw_in and edge_clear are
// sampled on every clk edge; buttons and edge_capture are levels, while press
// and release_pulse are single-cycle strobes that are never held or replayed.
// The release strobe is named release_pulse because 'release' is a reserved
// word in SystemVerilog.
interface button_debouncer_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] buttons;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] edge_capture;

  // Environment side: drives the pins and the clear mask.
  modport master (
    output raw_in,
    output edge_clear,
    input  buttons,
    input  press,
    input  release_pulse,
    input  edge_capture
  );

  // Debouncer side.
  modport slave (
    input  raw_in,
    input  edge_clear,
    output buttons,
    output press,
    output release_pulse,
    output edge_capture
  );

endinterface

// File: rtl/button_debouncer.sv
// Push-button / switch conditioner feeding the Buttons PIO in_port.
// Two-flop synchroniser, optional active-low inversion, per-bit stability
// counter, and one-cycle press/release strobes.
// Optional sticky press capture is enabled with `define BUTTON_EDGE_CAPTURE_EN;
// without it edge_capture is tied low and edge_clear is ignored.
module button_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input logic               clk,
  input logic               reset,
  button_debouncer_if.slave bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so this width never wraps.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Pin level of an unpressed button; the synchroniser resets to this so the
  // first synced samples after reset never look like a press.
  localparam logic [WIDTH-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;

  // Two-stage synchroniser bringing the asynchronous pins into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= PIN_IDLE;
      s2 <= PIN_IDLE;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  // Polarity normalisation after the synchroniser: 1 always means pressed.
  assign synced = (ACTIVE_LOW != 0) ? ~s2 : s2;

  // Each bit owns its own counter and runs on its own timeline.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             stable_q;
    logic             press_b;
    logic             release_b;

    // Count consecutive cycles the synced level disagrees with the accepted
    // level; any agreement restarts the count, reaching the limit accepts it.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt       <= '0;
        stable_q  <= 1'b0;
        press_b   <= 1'b0;
        release_b <= 1'b0;
      end else begin
        press_b   <= 1'b0;
        release_b <= 1'b0;
        if (synced[i] == stable_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt       <= '0;
          stable_q  <= synced[i];
          press_b   <= synced[i];
          release_b <= ~synced[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign stable[i]    = stable_q;
    assign press_q[i]   = press_b;
    assign release_q[i] = release_b;
  end

  assign bus.buttons       = stable;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;

`ifdef BUTTON_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] capture_q;

  // Sticky press flags; a press in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~bus.edge_clear) | press_q;
    end
  end

  assign bus.edge_capture = capture_q;
`else
  logic unused_edge_clear;

  assign unused_edge_clear = ^bus.edge_clear;
  assign bus.edge_capture  = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with WIDTH=16, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// A window-based reference model runs alongside the DUT; directed sequences
// pin latencies and glitch rejection with literal values.
module tb_button_debouncer;

  localparam int W  = 16;
  localparam int DC = 4;
  localparam logic [W-1:0] PIN_IDLE = {W{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_debouncer_if #(.WIDTH(W)) bus ();

  button_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins reach the filter two edges late (dly_q). A bit flips when the last
  // DC filter samples all disagree with its current accepted level.
  logic [W-1:0] dly_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_buttons;
  logic [W-1:0] exp_press;
  logic [W-1:0] exp_release;
  logic [W-1:0] exp_cap;
  logic [W-1:0] model_v;
  bit           model_valid = 1'b0;
  bit           all_new;

  always @(posedge clk) begin
    if (reset) begin
      dly_q       = '{PIN_IDLE, PIN_IDLE};
      exp_q.delete();
      exp_buttons = '0;
      exp_press   = '0;
      exp_release = '0;
      exp_cap     = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
`ifdef BUTTON_EDGE_CAPTURE_EN
      exp_cap = (exp_cap & ~bus.edge_clear) | exp_press;
`else
      exp_cap = '0;
`endif
      model_v = ~dly_q.pop_front();
      dly_q.push_back(bus.raw_in);
      exp_q.push_back(model_v);
      if (exp_q.size() > DC) void'(exp_q.pop_front());
      exp_press   = '0;
      exp_release = '0;
      if (exp_q.size() == DC) begin
        for (int i = 0; i < W; i++) begin
          all_new = 1'b1;
          foreach (exp_q[k]) if (exp_q[k][i] == exp_buttons[i]) all_new = 1'b0;
          if (all_new) begin
            exp_buttons[i] = ~exp_buttons[i];
            if (exp_buttons[i]) exp_press[i] = 1'b1;
            else exp_release[i] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison, half a cycle after the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_buttons", bus.buttons, exp_buttons);
      chk("cyc_press", bus.press, exp_press);
      chk("cyc_release", bus.release_pulse, exp_release);
      chk("cyc_edge_capture", bus.edge_capture, exp_cap);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts active edges (sampled #1 after) until the condition holds.
  // mode 0: any masked buttons bit set; mode 1: any masked release bit set.
  // Returns -1 if the bound expires.
  task automatic count_until(input int mode, input logic [W-1:0] mask, output int n);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      n++;
      if (mode == 0 && |(bus.buttons & mask)) return;
      if (mode == 1 && |(bus.release_pulse & mask)) return;
    end
    n = -1;
  endtask

  int           n;
  logic [W-1:0] seen;
  logic [W-1:0] r;

  initial begin
    reset          = 1'b1;
    bus.raw_in     = PIN_IDLE;
    bus.edge_clear = '0;
    idle_cycles(3);
    reset = 1'b0;

    // Idle after reset: nothing may appear.
    seen = '0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.buttons | bus.press | bus.release_pulse;
    end
    chk("idle_after_reset", seen, 16'h0000);

    // Single press on bit 0: accepted on edge DC+2 after s1 capture.
    bus.raw_in = 16'hFFFE;
    count_until(0, 16'h0001, n);
    chk_int("bit0_press_latency", n, 6);
    chk("bit0_press_pulse", bus.press, 16'h0001);
    @(posedge clk);
    #1;
    chk("bit0_press_gone", bus.press, 16'h0000);
    chk("bit0_buttons_held", bus.buttons, 16'h0001);
    @(negedge clk);
    bus.raw_in = PIN_IDLE;
    count_until(1, 16'h0001, n);
    chk_int("bit0_release_latency", n, 6);
    @(negedge clk);

    // Glitches on bit 3 shorter than the filter window.
    seen = '0;
    repeat (5) begin
      bus.raw_in = 16'hFFF7;
      repeat (3) begin
        @(negedge clk);
        seen = seen | ((bus.press | bus.buttons) & 16'h0008);
      end
      bus.raw_in = PIN_IDLE;
      repeat (3) begin
        @(negedge clk);
        seen = seen | ((bus.press | bus.buttons) & 16'h0008);
      end
    end
    idle_cycles(6);
    seen = seen | ((bus.press | bus.buttons) & 16'h0008);
    chk("glitch_bit3", seen, 16'h0000);

    // Eight bits pressed together resolve together.
    bus.raw_in = 16'hFF00;
    count_until(0, 16'h00FF, n);
    chk_int("byte_press_latency", n, 6);
    chk("byte_buttons", bus.buttons, 16'h00FF);
    chk("byte_press", bus.press, 16'h00FF);
    @(negedge clk);
    bus.raw_in = PIN_IDLE;
    count_until(1, 16'h00FF, n);
    chk_int("byte_release_latency", n, 6);
    chk("byte_release", bus.release_pulse, 16'h00FF);
    @(negedge clk);
    idle_cycles(4);

    // Reset in the middle of a count aborts it; the full latency applies again.
    bus.raw_in = 16'hFFDF;
    idle_cycles(3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_buttons", bus.buttons, 16'h0000);
    reset = 1'b0;
    count_until(0, 16'h0020, n);
    chk_int("after_reset_latency", n, 6);
    chk("after_reset_buttons", bus.buttons, 16'h0020);
    @(negedge clk);
    bus.raw_in = PIN_IDLE;
    idle_cycles(10);

    // Randomised pin activity with occasional clears and resets.
    repeat (3000) begin
      @(negedge clk);
      r = bus.raw_in;
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, W - 1)] = ~r[$urandom_range(0, W - 1)];
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, W - 1)] = ~r[$urandom_range(0, W - 1)];
      bus.raw_in     = r;
      bus.edge_clear = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      reset          = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    reset          = 1'b0;
    bus.edge_clear = '0;
    bus.raw_in     = PIN_IDLE;
    idle_cycles(10);
    bus.edge_clear = '1;
    @(negedge clk);
    bus.edge_clear = '0;
    @(negedge clk);

    // Sticky press capture on bit 2.
    bus.raw_in = 16'hFFFB;
    count_until(0, 16'h0004, n);
    chk_int("cap_press_latency", n, 6);
    @(posedge clk);
    #1;
`ifdef BUTTON_EDGE_CAPTURE_EN
    chk("cap_set", bus.edge_capture, 16'h0004);
    @(negedge clk);
    bus.edge_clear = 16'h0004;
    @(negedge clk);
    bus.edge_clear = '0;
    chk("cap_cleared", bus.edge_capture, 16'h0000);
    bus.raw_in = PIN_IDLE;
    count_until(1, 16'h0004, n);
    bus.raw_in = 16'hFFFB;
    count_until(0, 16'h0004, n);
    chk("cap_press_again", bus.press, 16'h0004);
    bus.edge_clear = 16'h0004;
    @(posedge clk);
    #1;
    bus.edge_clear = '0;
    chk("cap_set_wins", bus.edge_capture, 16'h0004);
`else
    chk("cap_tied_low", bus.edge_capture, 16'h0000);
`endif
    @(negedge clk);
    bus.raw_in = PIN_IDLE;
    idle_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditioning stage directly upstream of the 16-bit Buttons PIO input port; its debounced output drives that PIO's in_port.
- Synchronises raw asynchronous push-button and switch pins into clk, inverts active-low pins, and filters bounce with a per-bit stability counter.
- Also produces one-cycle press/release pulses for interrupt or edge logic elsewhere in the SoC.

Parameters:
- WIDTH, 16, number of button bits.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a changed level must hold before acceptance (10 ms at 50 MHz); legal range >= 1.
- ACTIVE_LOW, 1, 1 = raw pin low means pressed (inverted internally); 0 = no inversion.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  WIDTH  asynchronous button pins.
- buttons  output  WIDTH  debounced level, 1 = pressed; feeds Buttons PIO in_port.
- press  output  WIDTH  one-cycle pulse per bit on accepted 0->1 of buttons.
- release  output  WIDTH  one-cycle pulse per bit on accepted 1->0 of buttons.
- edge_clear  input  WIDTH  write-1-to-clear for edge_capture (see Optional Feature).
- edge_capture  output  WIDTH  sticky press flags (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Synchroniser: two flops per bit (s1 <= raw_in, s2 <= s1); inversion applied after s2 when ACTIVE_LOW=1. On reset s1/s2 load the released pin level (all ones if ACTIVE_LOW, else zeros), so no spurious press follows reset.
- Per-bit counter cnt, width $clog2(DEBOUNCE_CYCLES+1); per-bit register stable drives buttons.
- Each edge, per bit: if synced level == stable, cnt <= 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1: stable <= synced, cnt <= 0, and pulse the press or release bit. Otherwise cnt <= cnt+1.
- Any return to the stable level before acceptance zeroes cnt; counting restarts from 0 on the next difference. Glitches shorter than DEBOUNCE_CYCLES never reach buttons.
- Latency: if the new pin level is first captured into s1 on edge 1 and then held, buttons changes on edge DEBOUNCE_CYCLES+2. The press/release pulse is registered alongside stable, is high for exactly that one cycle, and is low on the following edge.
- press and release for the same bit are never high together. Bits are fully independent, so simultaneous changes on several bits each resolve on their own timeline.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset values: buttons = 0, press = 0, release = 0, edge_capture = 0, all cnt = 0.
- Reset asserted mid-count aborts the count. After reset deasserts, a pin still held pressed requires the full DEBOUNCE_CYCLES+2 again.

Optional Feature:
- Macro: BUTTON_EDGE_CAPTURE_EN.
- Defined: edge_capture[i] is set by press[i] and cleared by edge_clear[i]=1. If set and clear occur in the same cycle, set wins. Reset value 0.
- Undefined: edge_capture is tied to 0 and edge_clear is ignored; the ports remain so the interface is unchanged.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=16, ACTIVE_LOW=1):
- Reset with raw_in=16'hFFFF for 3 cycles, then release -> buttons=0, press=0, release=0 for 20 cycles.
- raw_in[0] driven 0 and held -> buttons[0]=1 exactly 6 edges after s1 capture; press[0]=1 for exactly that one cycle.
- raw_in[3] low for 3 cycles then high, repeated 5 times -> buttons[3] stays 0 and press[3] never asserts.
- raw_in = 16'hFF00 (bits 0-7 pressed) -> buttons=16'h00FF and press=16'h00FF in the same cycle. Restore to 16'hFFFF -> release=16'h00FF 6 edges later.
- Reset asserted for 1 cycle while bit 5 has been held low for 3 cycles -> buttons[5]=0; after reset, buttons[5]=1 only after another 6 edges.
- With BUTTON_EDGE_CAPTURE_EN: press bit 2 -> edge_capture=16'h0004. Pulse edge_clear=16'h0004 -> 0. Clear in the same cycle as a new press[2] -> edge_capture stays 16'h0004.
